// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_HOLD,
    GNT_STARVE,
    GNT_PIPE,
    GNT_AUX
  } grant_e;

  // Default-width write-back entry; modules with a different Width build their own.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [31:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Small FIFO queueing auxiliary-unit results ahead of the register-file write port.
module wb_aux_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [REG_AW-1:0]            push_rd,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [REG_AW-1:0]            head_rd,
  output logic [Width-1:0]             head_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [Width-1:0]  data_mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_rd   = rd_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr_q]   <= push_rd;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and an aux FIFO.
// Optional statistics counters enabled by defining WB_ARB_STATS_EN.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [Width-1:0]  wb_data,
  output logic              pipe_stall,
  input  logic              aux_valid,
  input  logic [REG_AW-1:0] aux_rd,
  input  logic [Width-1:0]  aux_data,
  output logic              aux_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [Width-1:0]  rf_wd
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_aux_grants,
  output logic [15:0]       stat_stall_cycles
`endif
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CntW-1:0]   fifo_count;
  logic [REG_AW-1:0] head_rd;
  logic [Width-1:0]  head_data;

  logic              hold_valid_q, hold_load;
  logic [REG_AW-1:0] hold_rd_q;
  logic [Width-1:0]  hold_data_q;
  logic [WaitW-1:0]  wait_q;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_wa_q, rf_wa_d;
  logic [Width-1:0]  rf_wd_q, rf_wd_d;

  logic   wb_req, starve;
  grant_e grant;

  assign pipe_stall = hold_valid_q;
  assign aux_ready  = (fifo_count < CntW'(DEPTH));
  assign fifo_push  = aux_valid && !fifo_full;
  assign wb_req     = wb_valid && (wb_rd != ZERO_REG) && !pipe_stall;
  assign starve     = !fifo_empty && (wait_q == WaitW'(MAX_WAIT));

  wb_aux_fifo #(
    .Width (Width),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_rd   (aux_rd),
    .push_data (aux_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_rd   (head_rd),
    .head_data (head_data)
  );

  always_comb begin
    grant = GNT_NONE;
    if (hold_valid_q)     grant = GNT_HOLD;
    else if (starve)      grant = GNT_STARVE;
    else if (wb_req)      grant = GNT_PIPE;
    else if (!fifo_empty) grant = GNT_AUX;
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_wa_d   = rf_wa_q;
    rf_wd_d   = rf_wd_q;
    fifo_pop  = 1'b0;
    hold_load = 1'b0;
    unique case (grant)
      GNT_HOLD: begin
        rf_we_d = 1'b1;
        rf_wa_d = hold_rd_q;
        rf_wd_d = hold_data_q;
      end
      GNT_STARVE, GNT_AUX: begin
        // x0 results still leave the FIFO but never reach the register file.
        fifo_pop  = 1'b1;
        rf_we_d   = (head_rd != ZERO_REG);
        rf_wa_d   = head_rd;
        rf_wd_d   = head_data;
        hold_load = (grant == GNT_STARVE) && wb_req;
      end
      GNT_PIPE: begin
        rf_we_d = 1'b1;
        rf_wa_d = wb_rd;
        rf_wd_d = wb_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      wait_q       <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      if (hold_load) begin
        hold_valid_q <= 1'b1;
        hold_rd_q    <= wb_rd;
        hold_data_q  <= wb_data;
      end else if (grant == GNT_HOLD) begin
        hold_valid_q <= 1'b0;
      end
      if (fifo_pop || fifo_empty)         wait_q <= '0;
      else if (wait_q != WaitW'(MAX_WAIT)) wait_q <= wait_q + WaitW'(1);
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] aux_grants_q, stall_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_grants_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      aux_grants_q   <= aux_grants_q + 16'(fifo_pop);
      stall_cycles_q <= stall_cycles_q + 16'(hold_valid_q);
    end
  end

  assign stat_aux_grants   = aux_grants_q;
  assign stat_stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes are queued with their due cycle.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid, aux_valid;
  logic [4:0]  wb_rd, aux_rd;
  logic [31:0] wb_data, aux_data;
  logic        pipe_stall, aux_ready, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_aux_grants, stat_stall_cycles;
`endif

  wb_port_arbiter #(
    .Width    (32),
    .DEPTH    (2),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .pipe_stall (pipe_stall),
    .aux_valid  (aux_valid),
    .aux_rd     (aux_rd),
    .aux_data   (aux_data),
    .aux_ready  (aux_ready),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_aux_grants   (stat_aux_grants),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   stall_due = -1;
  int   checks    = 0;
  int   failures  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic sb_push(input int due, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    int   i;
    e.due  = due;
    e.rd   = rd;
    e.data = data;
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, e);
  endtask

  task automatic check_outputs();
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check_val("rf_we", 32'(rf_we), 32'd1);
      check_val("rf_wa", 32'(rf_wa), 32'(sb[0].rd));
      check_val("rf_wd", rf_wd, sb[0].data);
      void'(sb.pop_front());
    end else begin
      check_val("rf_we_idle", 32'(rf_we), 32'd0);
    end
    check_val("pipe_stall", 32'(pipe_stall), 32'(cyc == stall_due));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #2;
    check_outputs();
  endtask

  task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    wb_valid  = wv;
    wb_rd     = wrd;
    wb_data   = wd;
    aux_valid = av;
    aux_rd    = ard;
    aux_data  = ad;
  endtask

  // Reset between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_val("rst_rf_we", 32'(rf_we), 32'd0);
    check_val("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    check_val("rst_aux_ready", 32'(aux_ready), 32'd1);
    sb.delete();
    stall_due = -1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    rst = 1'b0;
  endtask

  task automatic starve_scenario(input bit mid_reset);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 5'd3, 32'hA000_0000 + 32'(k), k < 2, (k == 0) ? 5'd8 : 5'd9,
            (k == 0) ? 32'h88 : 32'h99);
      if (k < 5) begin
        sb_push(cyc + 1, 5'd3, 32'hA000_0000 + 32'(k));
      end else begin
        sb_push(cyc + 2, 5'd3, 32'hA000_0005);
        stall_due = cyc + 1;
      end
      if (k == 0) sb_push(cyc + 6, 5'd8, 32'h88);
      if (k == 1) sb_push(cyc + 7, 5'd9, 32'h99);
      tick();
      check_val("aux_ready_starve", 32'(aux_ready), (k >= 1 && k <= 4) ? 32'd0 : 32'd1);
    end
    if (mid_reset) begin
      do_reset();
      repeat (6) tick();
    end else begin
      // Offered during the stall cycle; must be ignored.
      drive(1'b1, 5'd3, 32'hDEAD_0006, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      repeat (4) tick();
`ifdef WB_ARB_STATS_EN
      check_val("stat_aux_grants", 32'(stat_aux_grants), 32'd2);
      check_val("stat_stall_cycles", 32'(stat_stall_cycles), 32'd1);
`endif
    end
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    do_reset();
    check_val("rst_rf_wa", 32'(rf_wa), 32'd0);
    check_val("rst_rf_wd", rf_wd, 32'd0);
    tick();

    // Pipeline-only write.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    sb_push(cyc + 1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // x0 writes from either source are dropped.
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    tick();
    check_val("aux_ready_x0", 32'(aux_ready), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) tick();

    // Aux result with an idle pipeline: two-cycle latency.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    sb_push(cyc + 2, 5'd7, 32'h11);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) tick();

    // Back-to-back pipeline writes with distinct registers.
    for (int k = 1; k < 5; k++) begin
      drive(1'b1, 5'(k + 10), 32'h5000 + 32'(k), 1'b0, 5'd0, 32'd0);
      sb_push(cyc + 1, 5'(k + 10), 32'h5000 + 32'(k));
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    starve_scenario(1'b0);
    starve_scenario(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register-file write port between the in-order pipeline writeback (fifth stage: Writeback/rd/RegWrite) and a long-latency auxiliary unit (multiplier/divider).
- Pipeline writes normally win. Aux results queue in a small FIFO.
- A starvation counter forces an aux grant. The displaced pipeline write is parked in a one-entry hold register, and the pipeline is stalled for one cycle.

Parameters:
- Width, 32, data width of write-back values.
- DEPTH, 2, aux FIFO entries (power of two, >=2).
- MAX_WAIT, 4, cycles an aux head may wait before a forced grant (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high; clears all state.
- wb_valid  input  1  pipeline writeback valid (RegWrite of stage 5).
- wb_rd  input  5  pipeline destination register.
- wb_data  input  Width  pipeline Writeback value.
- pipe_stall  output  1  pipeline must freeze stage 4->5 this cycle.
- aux_valid  input  1  aux result offered.
- aux_rd  input  5  aux destination register.
- aux_data  input  Width  aux result.
- aux_ready  output  1  FIFO can accept; transfer occurs when aux_valid && aux_ready.
- rf_we  output  1  register-file write enable (registered).
- rf_wa  output  5  register-file write address (registered).
- rf_wd  output  Width  register-file write data (registered).

Behaviour:
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, pipe_stall=0, FIFO empty (aux_ready=1), hold register empty, wait_cnt=0.
- Reset asserted mid-operation discards all queued and held writes immediately; there is no partial write.
- Effective pipeline request: wb_req = wb_valid && wb_rd!=0 && !pipe_stall. wb_valid while pipe_stall=1 is ignored.
- Aux entries with rd=0 are popped normally but produce rf_we=0.
- Per-cycle grant priority:
  1. hold_valid: write hold entry, clear hold.
  2. starve = (FIFO non-empty && wait_cnt==MAX_WAIT): pop head and write it. If wb_req, capture wb_rd/wb_data into hold.
  3. wb_req: write pipeline entry.
  4. FIFO non-empty: pop head and write it.
  5. Otherwise rf_we=0 next cycle.
- The winning entry appears on rf_we/rf_wa/rf_wd on the next rising edge, so latency is 1 cycle from grant.
- Pipeline latency is 1 cycle (wb_valid at cycle N gives rf_we at N+1). Held entries take 2 cycles.
- Aux latency with an idle pipeline is 2 cycles (accepted at N, popped at N+1, written at N+2).
- pipe_stall = hold_valid, purely combinational from the register. It is high for exactly one cycle per forced grant.
- wait_cnt:
  - resets to 0 on any aux pop or when the FIFO is empty;
  - otherwise increments while the head is not granted;
  - saturates at MAX_WAIT.
- aux_ready = (count < DEPTH). There is no pop-through: when full, aux_ready=0 even in a popping cycle.
- Simultaneous push and pop (not full): count unchanged; pointers wrap modulo DEPTH.
- Same rd from both sources: no merging. Write order equals grant order. Register hazards are the scoreboard's responsibility upstream.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined: adds outputs stat_aux_grants[15:0] (counts aux pops) and stat_stall_cycles[15:0] (counts cycles with pipe_stall=1). Both counters wrap at 16 bits and reset to 0 on rst.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - REG_AW=5, ZERO_REG=5'd0;
  - grant enum {GNT_NONE, GNT_HOLD, GNT_STARVE, GNT_PIPE, GNT_AUX};
  - wb_entry struct {rd, data}.
- One sub-module, wb_aux_fifo: parameterised DEPTH/Width, push/pop/full/empty/count, head output.
- Arbitration, hold register, wait counter and output registers stay in the top module.

Test Plan:
- Pipe-only write: wb_valid=1, wb_rd=5, wb_data=32'hDEADBEEF at cycle N -> cycle N+1: rf_we=1, rf_wa=5, rf_wd=32'hDEADBEEF; pipe_stall stays 0.
- x0 drop: wb_valid=1, wb_rd=0, data=32'h1234 -> rf_we stays 0. Aux push rd=0 -> popped, aux_ready remains 1, rf_we=0.
- Aux with idle pipe: push rd=7, data=32'h11 at cycle N -> rf_we=1, rf_wa=7, rf_wd=32'h11 at N+2.
- Starvation (DEPTH=2, MAX_WAIT=4):
  - push 2 aux entries (rd=8 then rd=9) while wb_valid held with rd=3 -> aux_ready=0 while the FIFO is full;
  - after 4 waiting cycles, rd=8 is written;
  - the pipeline entry is held and pipe_stall=1 for one cycle;
  - the held rd=3 is written next; wait_cnt restarts for rd=9.
- Async reset mid-operation: FIFO holding 2 entries plus hold_valid, rst pulsed between clock edges -> rf_we=0, pipe_stall=0, aux_ready=1 immediately. No queued entry is ever written after release.
- With WB_ARB_STATS_EN defined, repeat the starvation scenario -> stat_aux_grants=2, stat_stall_cycles=1.
